gate_decoder_arbiter: RTL and testbench
=======================================

# gate_decoder_arbiter

Round-robin arbiter and sequencer that shares one decoder-based gate unit among `NUM_REQ` requesters. Each requester presents a 2-bit gate opcode and two operand bits. The block grants one requester, captures its operands, and evaluates the gate through a 2-to-4 minterm decoder. It then returns the result with the winner's ID. It sits above the basic decoder/demux gate blocks and gives them a multi-client interface.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_REQ: per-requester request level.
- `op`  in  2*NUM_REQ: opcode of requester i in bits `[2i+1:2i]`.
  - 00 NOT(a), 01 AND, 10 OR, 11 XOR.
- `a`  in  NUM_REQ: operand a, one bit per requester.
- `b`  in  NUM_REQ: operand b, one bit per requester (ignored for NOT).
- `gnt`  out  NUM_REQ: one-hot grant, high for exactly one cycle.
- `busy`  out  1: high in every state except IDLE.
- `rsp_valid`  out  1: result valid, one-cycle pulse.
- `rsp_id`  out  ID_W: index of the requester being answered.
- `rsp_y`  out  1: gate result.

## Operation
- FSM states: IDLE, GRANT, EVAL, RESP.
- IDLE → GRANT when `|req`.
  - On that edge the winner ID is latched, along with its `op`, `a` and `b`.
- GRANT drives `gnt[winner]=1`, then always goes to EVAL.
- EVAL registers the decoder-unit output into the result register, then goes to RESP.
- RESP drives `rsp_valid=1`, `rsp_id=winner` and `rsp_y`.
  - The priority pointer becomes `(winner+1) mod NUM_REQ`.
  - Next state is GRANT if `|req` (re-arbitrated with the new pointer), otherwise IDLE.
- Arbitration:
  - The first asserted `req` at or above `ptr` wins; the search wraps modulo `NUM_REQ`.
  - `ptr` resets to 0.
- Requester contract:
  - Hold `req`, `op`, `a`, `b` stable until `gnt` is seen.
  - Deassert `req` in the cycle after `gnt`, unless a further operation is wanted.
  - A `req` still high in RESP is treated as a new request.
- Operands are sampled only at arbitration. Changes after the sampling edge do not affect the in-flight result.
- Gate evaluation:
  - `m = decode2to4({a,b})`, which is one-hot.
  - `y = |(m & MASK[op])`.
  - Masks are indexed by minterm `{a,b}` = 11,10,01,00:
    - NOT = 4'b0011
    - AND = 4'b1000
    - OR = 4'b1110
    - XOR = 4'b0110
- Reset (any time, including mid-transaction):
  - State goes to IDLE, `ptr` to 0, and all latched fields to 0.
  - The in-flight operation is discarded and no `rsp_valid` is produced for it.
- Reset values: `gnt=0`, `busy=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_y=0`.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Request latency: with `req` first sampled high in IDLE at edge k:
  - `gnt` is high in cycle k+1.
  - `rsp_valid` is high in cycle k+3.
- Back-to-back throughput: one result every 3 cycles (GRANT, EVAL, RESP) while any `req` stays high.
- `rsp_id` and `rsp_y` hold their last values outside RESP. Only `rsp_valid` qualifies them.
- `gnt` and `rsp_valid` are never high in the same cycle.
- `busy` rises the cycle after the first sampled `req` and falls the cycle after RESP when no `req` is pending.

## Structure
- Package `gate_decoder_pkg` holds:
  - Opcode localparams: `OP_NOT`, `OP_AND`, `OP_OR`, `OP_XOR`.
  - The 4-bit minterm masks.
  - The FSM state encoding.
- Sub-module `gate_decoder_unit`: purely combinational.
  - Ports: `op[1:0]`, `a`, `b` in; `y` out.
  - Contains the 2-to-4 decoder and the mask OR.
  - Instantiated once inside the arbiter.
- The arbiter top holds the FSM, the round-robin pointer, the operand/ID latches and the result register.

## Test plan
1. NOT, single requester.
   - Reset, then req[0]=1 with op0=00, a0=0 → `gnt=0001` one cycle later, then `rsp_valid=1`, `rsp_id=0`, `rsp_y=1`.
   - Repeat with a0=1 → `rsp_y=0`.
2. Truth-table sweep.
   - Requester 1 sends all 16 combinations of op, a, b → results match AND/OR/XOR/NOT.
   - Each `rsp_valid` arrives exactly 3 cycles after its arbitration edge.
3. All-request contention.
   - Right after reset, `req=1111` held high → grants in order 0,1,2,3,0,…, spaced 3 cycles apart, with `rsp_id` matching each grant.
4. Fairness under pointer movement.
   - req[1] and req[3] held high with `ptr=0` → grant order 1,3,1,3.
   - No requester waits longer than `NUM_REQ` grants.
5. Operand stability.
   - Change a0 in the GRANT cycle → `rsp_y` reflects the value sampled at arbitration.
6. Reset mid-transaction.
   - Assert `rst_n=0` during EVAL → no `rsp_valid`; `gnt`, `busy` and `rsp_*` all read 0.
   - After release, `req=1111` → first grant goes to requester 0.

Source files
------------

// File: rtl/gate_decoder_pkg.sv
// Shared opcodes, minterm masks and FSM encoding for the gate decoder arbiter.
package gate_decoder_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Bit n of a mask is the gate output for minterm {a,b} == n.
    localparam logic [3:0] MASK_NOT = 4'b0011;
    localparam logic [3:0] MASK_AND = 4'b1000;
    localparam logic [3:0] MASK_OR  = 4'b1110;
    localparam logic [3:0] MASK_XOR = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EVAL  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [3:0] op_mask(input logic [1:0] op);
        logic [3:0] m;
        case (op)
            OP_NOT:  m = MASK_NOT;
            OP_AND:  m = MASK_AND;
            OP_OR:   m = MASK_OR;
            default: m = MASK_XOR;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/gate_decoder_unit.sv
// Combinational gate: 2-to-4 minterm decoder ANDed with the opcode mask.
module gate_decoder_unit
    import gate_decoder_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    logic [3:0] minterm;

    assign minterm = 4'b0001 << {a, b};
    assign y       = |(minterm & op_mask(op));

endmodule

// File: rtl/gate_decoder_arbiter.sv
// Round-robin arbiter sequencing NUM_REQ requesters through one shared gate unit.
module gate_decoder_arbiter
    import gate_decoder_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   op,
    input  logic [NUM_REQ-1:0]     a,
    input  logic [NUM_REQ-1:0]     b,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_y
);

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + ID_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, win_q, rsp_id_q;
    logic [1:0]        op_q;
    logic              a_q, b_q, y_q;
    logic              unit_y;

    logic [ID_W-1:0]      base;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 arb_hit, arb_en;
    logic [ID_W-1:0]      arb_id;
    logic [1:0]           op_sel;
    logic                 a_sel, b_sel;
    int                   off, idx;

    // In RESP the search already starts one past the current winner.
    always_comb begin
        base    = (state_q == ST_RESP) ? next_ptr(win_q) : ptr_q;
        req_dbl = {req, req};
        req_rot = NUM_REQ'(req_dbl >> base);
        arb_hit = 1'b0;
        off     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                arb_hit = 1'b1;
                off     = k;
            end
        end
        idx = int'(base) + off;
        if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
        end
        arb_id = ID_W'(idx);
        op_sel = 2'b00;
        a_sel  = 1'b0;
        b_sel  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_id == ID_W'(i)) begin
                op_sel = op[2*i +: 2];
                a_sel  = a[i];
                b_sel  = b[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        arb_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_hit) begin
                    state_d = ST_GRANT;
                    arb_en  = 1'b1;
                end
            end
            ST_GRANT: state_d = ST_EVAL;
            ST_EVAL:  state_d = ST_RESP;
            ST_RESP: begin
                if (arb_hit) begin
                    state_d = ST_GRANT;
                    arb_en  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            op_q     <= 2'b00;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            y_q      <= 1'b0;
            rsp_id_q <= '0;
        end else begin
            state_q <= state_d;
            if (arb_en) begin
                win_q <= arb_id;
                op_q  <= op_sel;
                a_q   <= a_sel;
                b_q   <= b_sel;
            end
            // Result and ID move together so both hold until the next RESP.
            if (state_q == ST_EVAL) begin
                y_q      <= unit_y;
                rsp_id_q <= win_q;
            end
            if (state_q == ST_RESP) begin
                ptr_q <= next_ptr(win_q);
            end
        end
    end

    gate_decoder_unit u_gate (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (unit_y)
    );

    assign gnt       = (state_q == ST_GRANT) ? (NUM_REQ'(1) << win_q) : '0;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = y_q;

endmodule

// File: tb/tb_gate_decoder_arbiter.sv
// Bench for gate_decoder_arbiter: directed tables, corner sequences and a random run vs. a transaction model.
module tb_gate_decoder_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [2*N-1:0]  op = '0;
    logic [N-1:0]    a = '0;
    logic [N-1:0]    b = '0;
    logic [N-1:0]    gnt;
    logic            busy;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic            rsp_y;

    int n_cmp = 0;
    int n_err = 0;

    gate_decoder_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op        (op),
        .a         (a),
        .b         (b),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_gate(input logic [1:0] o, input logic x, input logic y);
        case (o)
            2'b00:   return ~x;
            2'b01:   return x & y;
            2'b10:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    // Transaction-level reference: an accepted request owns the unit for three
    // cycles (grant, eval, response); the next winner is searched from winner+1.
    int           cyc = 0;
    int           arb_ok_at = 0;
    int           rsp_at = -1;
    int           mptr = 0;
    int           w;
    logic [IW-1:0] pend_id = '0, last_id = '0;
    logic         pend_y = 1'b0, last_y = 1'b0;
    logic [N-1:0] r_c, eg;
    logic [2*N-1:0] op_c;
    logic [N-1:0] a_c, b_c;
    logic         rs_c, ev;

    initial begin
        forever begin
            @(posedge clk);
            r_c  = req;
            op_c = op;
            a_c  = a;
            b_c  = b;
            rs_c = rst_n;
            cyc++;
            eg = '0;
            if (!rs_c) begin
                arb_ok_at = 0;
                rsp_at    = -1;
                mptr      = 0;
                last_id   = '0;
                last_y    = 1'b0;
            end else begin
                if (cyc >= arb_ok_at && r_c != '0) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && r_c[(mptr + k) % N]) w = (mptr + k) % N;
                    end
                    eg[w]     = 1'b1;
                    pend_id   = IW'(w);
                    pend_y    = ref_gate(op_c[2*w +: 2], a_c[w], b_c[w]);
                    rsp_at    = cyc + 2;
                    arb_ok_at = cyc + 3;
                    mptr      = (w + 1) % N;
                end
                if (cyc == rsp_at) begin
                    last_id = pend_id;
                    last_y  = pend_y;
                end
            end
            ev = rs_c && (cyc == rsp_at);
            @(negedge clk);
            chk("mon_gnt", gnt, eg);
            chk("mon_busy", busy, rs_c && (cyc < arb_ok_at));
            chk("mon_rsp_valid", rsp_valid, ev);
            chk("mon_rsp_id", rsp_id, last_id);
            chk("mon_rsp_y", rsp_y, last_y);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output int waited);
        g      = '0;
        waited = 0;
        for (int t = 0; t < 20 && g == '0; t++) begin
            tick();
            waited++;
            g = gnt;
        end
        if (g == '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL gnt_timeout: got no grant within 20 cycles at %0t", $time);
        end
    endtask

    task automatic do_op(input int id, input logic [1:0] o, input logic x, input logic y,
                         input logic expy, input logic chg);
        logic [N-1:0] g;
        int waited;
        op[2*id +: 2] = o;
        a[id]   = x;
        b[id]   = y;
        req[id] = 1'b1;
        wait_gnt(g, waited);
        chk("op_gnt", g, 32'(1) << id);
        req[id] = 1'b0;
        if (chg) a[id] = ~x;
        tick();
        chk("op_eval_no_rsp", rsp_valid, 1'b0);
        tick();
        chk("op_rsp_valid", rsp_valid, 1'b1);
        chk("op_rsp_id", rsp_id, id);
        chk("op_rsp_y", rsp_y, expy);
        tick();
    endtask

    task automatic rr_seq(input logic [N-1:0] rq, input int cnt, input int first);
        logic [N-1:0] g;
        int waited, exp_id;
        exp_id = first;
        req = rq;
        for (int gi = 0; gi < cnt; gi++) begin
            wait_gnt(g, waited);
            chk("rr_gnt", g, 32'(1) << exp_id);
            if (gi > 0) chk("rr_spacing", waited, 1);
            tick();
            tick();
            chk("rr_rsp_id", rsp_id, exp_id);
            chk("rr_rsp_valid", rsp_valid, 1'b1);
            do begin
                exp_id = (exp_id + 1) % N;
            end while (!rq[exp_id]);
        end
        req = '0;
        tick();
        tick();
    endtask

    typedef struct {
        logic [1:0] op;
        logic       a;
        logic       b;
        logic       y;
    } vec_t;

    vec_t tt[16];

    initial begin
        logic [N-1:0] g;
        int waited;

        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
        g = '0;
        waited = 0;
    end

    initial begin
        logic [N-1:0] g;
        int waited;

        for (int i = 0; i < 16; i++) begin
            tt[i].op = 2'(i >> 2);
            tt[i].a  = i[1];
            tt[i].b  = i[0];
            tt[i].y  = ref_gate(tt[i].op, tt[i].a, tt[i].b);
        end

        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_y", rsp_y, 0);
        rst_n = 1'b1;
        tick();

        // NOT on requester 0
        do_op(0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op(0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // truth-table sweep on requester 1
        for (int i = 0; i < 16; i++) begin
            do_op(1, tt[i].op, tt[i].a, tt[i].b, tt[i].y, 1'b0);
        end

        // operand change in the GRANT cycle must not leak into the result
        do_op(0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
        do_op(2, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);

        // all-request contention, then fairness with two requesters
        do_reset();
        rr_seq(4'b1111, 8, 0);
        do_reset();
        rr_seq(4'b1010, 4, 1);

        // reset during EVAL
        do_op(3, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
        op[1:0] = 2'b10;
        a[0]    = 1'b1;
        req[0]  = 1'b1;
        wait_gnt(g, waited);
        chk("mid_gnt", g, 4'b0001);
        req[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_gnt0", gnt, 0);
        chk("mid_busy0", busy, 0);
        chk("mid_rsp_valid0", rsp_valid, 0);
        chk("mid_rsp_id0", rsp_id, 0);
        chk("mid_rsp_y0", rsp_y, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_no_rsp", rsp_valid, 0);
        req = 4'b1111;
        wait_gnt(g, waited);
        chk("mid_first_gnt", g, 4'b0001);
        req = '0;
        tick();
        tick();
        tick();

        // random traffic against the reference model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        op[2*i +: 2] = 2'($urandom_range(3, 0));
                        a[i] = 1'($urandom_range(1, 0));
                        b[i] = 1'($urandom_range(1, 0));
                    end else begin
                        req[i] = 1'b0;
                        a[i]   = 1'($urandom_range(1, 0));
                    end
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    op[2*i +: 2] = 2'($urandom_range(3, 0));
                    a[i] = 1'($urandom_range(1, 0));
                    b[i] = 1'($urandom_range(1, 0));
                end
            end
        end
        req = '0;
        for (int t = 0; t < 6; t++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
